// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: UART register block with TX/RX data FIFOs, programmable
// baud divisor, sticky W1C interrupt status and registered read data.
module uart_csr_fifo #(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 8,
   parameter int                TX_DEPTH = 8,
   parameter int                RX_DEPTH = 8,
   parameter int                DIV_W    = 16,
   parameter logic [DIV_W-1:0]  DIV_RST  = DIV_W'(54)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   output logic              wack,
   output logic              waddrerr,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata,
   output logic              rack,
   output logic              raddrerr,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              tx_done,
   input  logic              parity_error,
   output logic [1:0]        data_bit_num,
   output logic              stop_bit_num,
   output logic              parity_en,
   output logic              parity_type,
   output logic [DIV_W-1:0]  baud_div,
   output logic              irq
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);

   localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'('h00);
   localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'('h04);
   localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'('h08);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'('h0C);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'('h10);
   localparam logic [ADDR_W-1:0] A_INTST  = ADDR_W'('h14);
   localparam logic [ADDR_W-1:0] A_INTEN  = ADDR_W'('h18);
   localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'('h1C);

   // registered state
   logic [TX_AW:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [RX_AW:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [DATA_W-1:0]   tx_mem_q [TX_DEPTH];
   logic [DATA_W-1:0]   rx_mem_q [RX_DEPTH];
   logic [4:0]          cfg_q, cfg_d;
   logic                tx_en_q, tx_en_d;
   logic [4:0]          int_stat_q, int_stat_d;
   logic [4:0]          int_en_q, int_en_d;
   logic [DIV_W-1:0]    baud_q, baud_d;
   logic                wack_q, wack_d, waddrerr_q, waddrerr_d;
   logic                rack_q, rack_d, raddrerr_q, raddrerr_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                irq_q, irq_d;

   // combinational helpers
   logic                wr_txdata, wr_cfg, wr_ctrl, wr_intst, wr_inten, wr_baud, wr_hit;
   logic                rd_rxdata, rd_hit;
   logic                tx_flush, rx_flush;
   logic [TX_AW:0]      tx_cnt;
   logic [RX_AW:0]      rx_cnt;
   logic                tx_empty, tx_full, rx_empty, rx_full;
   logic                tx_pop, tx_push_ok, tx_ovf;
   logic                rx_pop_req, rx_push_ok, rx_ovf;
   logic                tx_we, rx_we;
   logic [DATA_W-1:0]   tx_head, rx_head;
   logic [4:0]          int_set, int_clr;
   logic                unused_wdata;

   // Address decode, FIFO occupancy and heads.
   always_comb begin
      wr_txdata = wr_en && (waddr == A_TXDATA);
      wr_cfg    = wr_en && (waddr == A_CFG);
      wr_ctrl   = wr_en && (waddr == A_CTRL);
      wr_intst  = wr_en && (waddr == A_INTST);
      wr_inten  = wr_en && (waddr == A_INTEN);
      wr_baud   = wr_en && (waddr == A_BAUD);
      wr_hit    = wr_txdata || wr_cfg || wr_ctrl || wr_intst || wr_inten || wr_baud;

      rd_rxdata = rd_en && (raddr == A_RXDATA);
      rd_hit    = (raddr == A_TXDATA) || (raddr == A_RXDATA) || (raddr == A_CFG)
               || (raddr == A_CTRL)   || (raddr == A_STATUS) || (raddr == A_INTST)
               || (raddr == A_INTEN)  || (raddr == A_BAUD);

      tx_flush  = wr_ctrl && wdata[2];
      rx_flush  = wr_ctrl && wdata[1];

      tx_cnt    = tx_wptr_q - tx_rptr_q;
      rx_cnt    = rx_wptr_q - rx_rptr_q;
      tx_empty  = (tx_wptr_q == tx_rptr_q);
      rx_empty  = (rx_wptr_q == rx_rptr_q);
      // full: same slot index, opposite wrap bit
      tx_full   = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW])
               && (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
      rx_full   = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW])
               && (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);

      tx_head   = tx_empty ? '0 : tx_mem_q[tx_rptr_q[TX_AW-1:0]];
      rx_head   = rx_empty ? '0 : rx_mem_q[rx_rptr_q[RX_AW-1:0]];

      unused_wdata = ^wdata;
   end

   // FIFO pointer updates; flush wins over any same-cycle push or pop.
   always_comb begin
      tx_pop     = tx_en_q && !tx_empty && tx_ready;
      tx_push_ok = wr_txdata && (!tx_full || tx_pop) && !tx_flush;
      tx_ovf     = wr_txdata && tx_full && !tx_pop && !tx_flush;
      tx_we      = tx_push_ok;
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      if (tx_flush) begin
         tx_wptr_d = '0;
         tx_rptr_d = '0;
      end else begin
         if (tx_push_ok) tx_wptr_d = tx_wptr_q + 1'b1;
         if (tx_pop)     tx_rptr_d = tx_rptr_q + 1'b1;
      end

      rx_pop_req = rd_rxdata && !rx_empty;
      rx_push_ok = rx_valid && (!rx_full || rx_pop_req) && !rx_flush;
      rx_ovf     = rx_valid && rx_full && !rx_pop_req && !rx_flush;
      rx_we      = rx_push_ok;
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      if (rx_flush) begin
         rx_wptr_d = '0;
         rx_rptr_d = '0;
      end else begin
         if (rx_push_ok) rx_wptr_d = rx_wptr_q + 1'b1;
         if (rx_pop_req) rx_rptr_d = rx_rptr_q + 1'b1;
      end
   end

   // Register writes, sticky interrupt status and write acknowledge.
   always_comb begin
      cfg_d      = cfg_q;
      tx_en_d    = tx_en_q;
      int_en_d   = int_en_q;
      baud_d     = baud_q;
      if (wr_cfg)   cfg_d    = wdata[4:0];
      if (wr_ctrl)  tx_en_d  = wdata[0];
      if (wr_inten) int_en_d = wdata[4:0];
      if (wr_baud)  baud_d   = wdata[DIV_W-1:0];

      // hardware set is OR'ed after the clear so it wins a same-cycle W1C
      int_set    = {tx_ovf, rx_ovf, parity_error, rx_push_ok, tx_done};
      int_clr    = wr_intst ? wdata[4:0] : 5'b0;
      int_stat_d = (int_stat_q & ~int_clr) | int_set;

      wack_d     = wr_en;
      waddrerr_d = wr_en && !wr_hit;
      irq_d      = |(int_stat_q & int_en_q);
   end

   // Read data mux; rdata holds between reads.
   always_comb begin
      rdata_d    = rdata_q;
      rack_d     = rd_en;
      raddrerr_d = rd_en && !rd_hit;
      if (rd_en) begin
         unique case (raddr)
            A_RXDATA: rdata_d = 32'(rx_head);
            A_CFG:    rdata_d = 32'(cfg_q);
            A_CTRL:   rdata_d = 32'(tx_en_q);
            A_STATUS: rdata_d = {8'b0, 8'(rx_cnt), 8'(tx_cnt),
                                 4'b0, rx_full, rx_empty, tx_full, tx_empty};
            A_INTST:  rdata_d = 32'(int_stat_q);
            A_INTEN:  rdata_d = 32'(int_en_q);
            A_BAUD:   rdata_d = 32'(baud_q);
            default:  rdata_d = '0;
         endcase
      end
   end

   // State and control flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         cfg_q      <= '0;
         tx_en_q    <= 1'b0;
         int_stat_q <= '0;
         int_en_q   <= '0;
         baud_q     <= DIV_RST;
         wack_q     <= 1'b0;
         waddrerr_q <= 1'b0;
         rack_q     <= 1'b0;
         raddrerr_q <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         cfg_q      <= cfg_d;
         tx_en_q    <= tx_en_d;
         int_stat_q <= int_stat_d;
         int_en_q   <= int_en_d;
         baud_q     <= baud_d;
         wack_q     <= wack_d;
         waddrerr_q <= waddrerr_d;
         rack_q     <= rack_d;
         raddrerr_q <= raddrerr_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   // FIFO storage; contents are only visible through non-empty heads.
   always_ff @(posedge clk) begin
      if (tx_we) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= wdata[DATA_W-1:0];
      if (rx_we) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_data;
   end

   assign wack         = wack_q;
   assign waddrerr     = waddrerr_q;
   assign rack         = rack_q;
   assign raddrerr     = raddrerr_q;
   assign rdata        = rdata_q;
   assign tx_data      = tx_head;
   assign tx_valid     = tx_en_q && !tx_empty;
   assign data_bit_num = cfg_q[1:0];
   assign stop_bit_num = cfg_q[2];
   assign parity_en    = cfg_q[3];
   assign parity_type  = cfg_q[4];
   assign baud_div     = baud_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_uart_csr_fifo.sv
// tb_uart_csr_fifo: directed bench with read/TX/RX scoreboard queues.
module tb_uart_csr_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        wack, waddrerr;
   logic        rd_en;
   logic [11:0] raddr;
   logic [31:0] rdata;
   logic        rack, raddrerr;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, tx_done, parity_error;
   logic [1:0]  data_bit_num;
   logic        stop_bit_num, parity_en, parity_type;
   logic [15:0] baud_div;
   logic        irq;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [31:0] rd_q [$];
   logic        err_q [$];
   logic [7:0]  tx_q [$];
   logic [7:0]  rx_q [$];

   uart_csr_fifo #(.ADDR_W(12), .DATA_W(8), .TX_DEPTH(8), .RX_DEPTH(8),
                   .DIV_W(16), .DIV_RST(16'd54)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wack(wack), .waddrerr(waddrerr),
      .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rack(rack), .raddrerr(raddrerr),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done),
      .parity_error(parity_error), .data_bit_num(data_bit_num),
      .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
      .baud_div(baud_div), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d,
                     input logic experr);
      waddr = a; wdata = d; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      chk({tag, "_wack"}, 32'(wack), 32'd1);
      chk({tag, "_waddrerr"}, 32'(waddrerr), 32'(experr));
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                     input logic experr);
      rd_q.push_back(exp);
      err_q.push_back(experr);
      raddr = a; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      for (int i = 0; i < 4 && rack !== 1'b1; i++) step();
      chk({tag, "_rack"}, 32'(rack), 32'd1);
      chk({tag, "_rdata"}, rdata, rd_q.pop_front());
      chk({tag, "_raddrerr"}, 32'(raddrerr), 32'(err_q.pop_front()));
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; waddr = '0; wdata = '0; rd_en = 1'b0; raddr = '0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_done = 1'b0; parity_error = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();

      // 1: reset state
      chk("rst_rack", 32'(rack), 32'd0);
      chk("rst_wack", 32'(wack), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_baud_div", 32'(baud_div), 32'd54);
      rd("rst_baud", 12'h01C, 32'd54, 1'b0);
      rd("rst_status", 12'h010, 32'h0000_0005, 1'b0);

      // 2: TX path and tx_done interrupt
      wr("ctrl_en", 12'h00C, 32'h1, 1'b0);
      wr("tx41", 12'h000, 32'h41, 1'b0); tx_q.push_back(8'h41);
      wr("tx42", 12'h000, 32'h42, 1'b0); tx_q.push_back(8'h42);
      chk("tx_valid_hold", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
      for (int i = 0; i < 8 && tx_q.size() > 0; i++) begin
         if (tx_valid) chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
         step();
      end
      tx_ready = 1'b0;
      chk("tx_drained", 32'(tx_q.size()), 32'd0);
      chk("tx_valid_empty", 32'(tx_valid), 32'd0);
      rd("status_tx_empty", 12'h010, 32'h0000_0005, 1'b0);
      wr("inten1", 12'h018, 32'h01, 1'b0);
      tx_done = 1'b1; step(); tx_done = 1'b0;
      step();
      chk("irq_txdone", 32'(irq), 32'd1);
      rd("intst_txdone", 12'h014, 32'h01, 1'b0);
      wr("w1c_txdone", 12'h014, 32'h01, 1'b0);
      step();
      chk("irq_cleared", 32'(irq), 32'd0);

      // 3: RX fill past full
      for (int i = 0; i < 9; i++) begin
         rx_data = 8'(8'h10 + i);
         if (i < 8) rx_q.push_back(8'(8'h10 + i));
         rx_valid = 1'b1; step();
      end
      rx_valid = 1'b0;
      rd("status_rx_full", 12'h010, 32'h0008_0009, 1'b0);
      rd("intst_rx_ovf", 12'h014, 32'h0000_000A, 1'b0);
      chk("irq_masked", 32'(irq), 32'd0);
      for (int i = 0; i < 8; i++) rd("rxdata", 12'h004, 32'(rx_q.pop_front()), 1'b0);
      rd("rxdata_empty", 12'h004, 32'd0, 1'b0);
      wr("w1c_all", 12'h014, 32'h1F, 1'b0);

      // 4: address errors leave registers untouched
      wr("cfg", 12'h008, 32'h15, 1'b0);
      wr("baud", 12'h01C, 32'h1234, 1'b0);
      chk("data_bit_num", 32'(data_bit_num), 32'd1);
      chk("stop_bit_num", 32'(stop_bit_num), 32'd1);
      chk("parity_en", 32'(parity_en), 32'd0);
      chk("parity_type", 32'(parity_type), 32'd1);
      chk("baud_div", 32'(baud_div), 32'h1234);
      wr("werr_20", 12'h020, 32'hFFFF_FFFF, 1'b1);
      wr("werr_04", 12'h004, 32'hFFFF_FFFF, 1'b1);
      wr("werr_10", 12'h010, 32'hFFFF_FFFF, 1'b1);
      wr("werr_09", 12'h009, 32'hFFFF_FFFF, 1'b1);
      rd("rerr_24", 12'h024, 32'd0, 1'b1);
      rd("cfg_kept", 12'h008, 32'h15, 1'b0);
      rd("inten_kept", 12'h018, 32'h01, 1'b0);
      rd("baud_kept", 12'h01C, 32'h1234, 1'b0);
      rd("intst_kept", 12'h014, 32'h0, 1'b0);
      rd("txdata_rd0", 12'h000, 32'h0, 1'b0);

      // 5: hardware set beats same-cycle W1C
      parity_error = 1'b1; step(); parity_error = 1'b0;
      rd("intst_parity", 12'h014, 32'h04, 1'b0);
      parity_error = 1'b1;
      wr("w1c_vs_set", 12'h014, 32'h04, 1'b0);
      parity_error = 1'b0;
      rd("intst_set_wins", 12'h014, 32'h04, 1'b0);
      wr("w1c_parity", 12'h014, 32'h04, 1'b0);
      rd("intst_parity_clr", 12'h014, 32'h00, 1'b0);

      // 6: TX hold, overflow, flush, then async reset mid-transfer
      wr("ctrl_dis", 12'h00C, 32'h0, 1'b0);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr("tx_fill", 12'h000, 32'(8'h60 + i), 1'b0);
      chk("tx_valid_dis", 32'(tx_valid), 32'd0);
      rd("status_tx_full", 12'h010, 32'h0000_0806, 1'b0);
      wr("tx_ovf", 12'h000, 32'h99, 1'b0);
      rd("intst_tx_ovf", 12'h014, 32'h10, 1'b0);
      wr("tx_flush", 12'h00C, 32'h4, 1'b0);
      rd("status_flushed", 12'h010, 32'h0000_0005, 1'b0);
      chk("tx_valid_flush", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;
      wr("ctrl_en2", 12'h00C, 32'h1, 1'b0);
      wr("tx77", 12'h000, 32'h77, 1'b0);
      chk("tx_valid_pre_rst", 32'(tx_valid), 32'd1);
      tx_done = 1'b1; step(); tx_done = 1'b0;
      step();
      chk("irq_pre_rst", 32'(irq), 32'd1);
      raddr = 12'h01C; rd_en = 1'b1;
      waddr = 12'h008; wdata = 32'h3; wr_en = 1'b1;
      step();
      rd_en = 1'b0; wr_en = 1'b0;
      chk("inflight_rack", 32'(rack), 32'd1);
      chk("inflight_wack", 32'(wack), 32'd1);
      chk("inflight_dbn", 32'(data_bit_num), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rack", 32'(rack), 32'd0);
      chk("arst_wack", 32'(wack), 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      chk("arst_tx_valid", 32'(tx_valid), 32'd0);
      chk("arst_tx_data", 32'(tx_data), 32'd0);
      chk("arst_baud", 32'(baud_div), 32'd54);
      chk("arst_cfg", 32'({parity_type, parity_en, stop_bit_num, data_bit_num}), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      rd("post_rst_status", 12'h010, 32'h0000_0005, 1'b0);
      rd("post_rst_inten", 12'h018, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_csr_fifo.md
Name: uart_csr_fifo

Overview:
Parametrised second-generation UART register block. It bridges the simple wr/rd register bus to the UART TX/RX datapaths. Compared with the single-register generation, it adds:
- TX and RX data FIFOs of configurable depth.
- A programmable baud divisor.
- Sticky write-1-to-clear interrupt status with per-bit enables and a single irq output.
- Registered read data with an aligned read acknowledge.

It sits between the bus slave interface and the uart_tx / uart_rx engines.

Parameters:
ADDR_W, 12, register address width (byte address, word aligned)
DATA_W, 8, UART character width held in FIFOs (5..9)
TX_DEPTH, 8, TX FIFO entries (power of 2, 2..128)
RX_DEPTH, 8, RX FIFO entries (power of 2, 2..128)
DIV_W, 16, baud divisor width
DIV_RST, 16'd54, baud divisor reset value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, one cycle per write
waddr  in  ADDR_W  write address
wdata  in  32  write data
wack  out  1  write acknowledge, 1 cycle after wr_en
waddrerr  out  1  write address error, valid with wack
rd_en  in  1  read strobe, one cycle per read
raddr  in  ADDR_W  read address
rdata  out  32  read data, valid with rack
rack  out  1  read acknowledge, 1 cycle after rd_en
raddrerr  out  1  read address error, valid with rack
tx_data  out  DATA_W  TX FIFO head
tx_valid  out  1  TX FIFO non-empty and CTRL.tx_en set
tx_ready  in  1  TX engine takes head when tx_valid & tx_ready
rx_data  in  DATA_W  received character
rx_valid  in  1  one-cycle push into RX FIFO
tx_done  in  1  one-cycle pulse, character transmitted
parity_error  in  1  one-cycle pulse, RX parity fail
data_bit_num  out  2  CFG[1:0]
stop_bit_num  out  1  CFG[2]
parity_en  out  1  CFG[3]
parity_type  out  1  CFG[4]
baud_div  out  DIV_W  BAUD register
irq  out  1  |(INT_STAT & INT_EN), registered

Behaviour:
- Register map (all others are errors):
  - 0x00 TXDATA, WO: write pushes wdata[DATA_W-1:0]; reads return 0.
  - 0x04 RXDATA, RO: read pops the head into rdata; if empty, rdata=0 with no pop.
  - 0x08 CFG, RW [4:0].
  - 0x0C CTRL: [0] tx_en RW. [1] rx_flush and [2] tx_flush are write-1 pulses and read 0.
  - 0x10 STATUS, RO: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count.
  - 0x14 INT_STAT, W1C: [0] tx_done, [1] rx_avail (set per rx push), [2] parity_err, [3] rx_overflow, [4] tx_overflow.
  - 0x18 INT_EN, RW [4:0].
  - 0x1C BAUD, RW [DIV_W-1:0].
- Reset values:
  - FIFOs empty; tx_valid=0; tx_data=0.
  - CFG=0, CTRL=0, INT_STAT=0, INT_EN=0, baud_div=DIV_RST.
  - wack=rack=waddrerr=raddrerr=irq=0; rdata=0.
- Write path: on wr_en, the register updates at the next edge. wack=1 for exactly one cycle after it, with waddrerr=1 if the address is unmapped or is 0x04/0x10. Erroring writes change nothing.
- Read path: on rd_en, rdata and rack register at the next edge. rack is a one-cycle pulse; raddrerr=1 for unmapped addresses, with rdata=0. rdata holds its value between reads.
- Write and read channels are independent; wr_en and rd_en may be asserted in the same cycle.
- TX FIFO: pushed by a TXDATA write, popped on tx_valid & tx_ready.
  - Push while full: data dropped, INT_STAT[4] set.
  - Push and pop in the same cycle when full: both succeed.
  - tx_en=0 holds the FIFO contents and forces tx_valid=0.
- RX FIFO: pushed on rx_valid, popped by an RXDATA read.
  - Push while full with no simultaneous pop: data dropped, INT_STAT[3] set.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
- Flush: a flush empties the FIFO at the next edge and has priority over a same-cycle push or pop, which is discarded. Flush does not affect INT_STAT.
- Pointers: read/write pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty. Counts are 0..DEPTH.
- INT_STAT: bits are sticky. W1C clears only the bits written as 1. A hardware set in the same cycle as a W1C of that bit wins (bit stays 1).
- irq: registered from INT_STAT & INT_EN; it goes high 1 cycle after the enabling condition and falls 1 cycle after the clear.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and in-flight acks are dropped.

Test Plan:
1. Reset, read 0x1C -> rack 1 cycle later, rdata=DIV_RST. Read 0x10 -> rdata=0x0000_0005.
2. Write TXDATA 0x41,0x42 with tx_en=1 and tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive pops; tx_empty=1 after. A tx_done pulse sets INT_STAT[0]; with INT_EN=0x01, irq=1. Writing 0x14=0x01 drops irq.
3. Push RX_DEPTH+1 characters on rx_valid -> rx_full=1, INT_STAT[3]=1, rx_count=RX_DEPTH. RXDATA reads return the first RX_DEPTH values in order; a read when empty returns 0.
4. Write 0x20 and read 0x24 -> wack with waddrerr=1, rack with raddrerr=1, rdata=0, no register changed.
5. parity_error pulse in the same cycle as a 0x14=0x04 write -> INT_STAT[2] remains 1.
6. Fill TX with tx_en=0, write CTRL=0x4 -> tx_count=0 next cycle, tx_valid stays 0. Assert rst_n low mid-transfer -> all outputs at reset values.
